// File: rtl/led_fill_drain_rev.sv
// led_fill_drain_rev: 8-LED fill/drain chaser advanced by a clk_50M prescaler.
// Define LED_HOLD_EN to add hold phases at full and empty (HOLD_STEPS steps each).
module led_fill_drain_rev #(
  parameter int DIV        = 25000000,
  parameter int HOLD_STEPS = 2
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] out,
  output logic [1:0] phase,
  output logic       step
);

  // state      | meaning
  // FILL       | LEDs light one per step from bit 7 toward bit 0
  // HOLD_FULL  | all LEDs lit, wait HOLD_STEPS steps (LED_HOLD_EN only)
  // DRAIN      | LEDs turn off one per step from bit 7 toward bit 0
  // HOLD_EMPTY | all LEDs dark, wait HOLD_STEPS steps (LED_HOLD_EN only)
  localparam logic [1:0] FILL  = 2'b00;
  localparam logic [1:0] DRAIN = 2'b10;
`ifdef LED_HOLD_EN
  localparam logic [1:0] HOLD_FULL  = 2'b01;
  localparam logic [1:0] HOLD_EMPTY = 2'b11;
  localparam int HW = $clog2(HOLD_STEPS + 1);

  logic [HW-1:0] hold_cnt;
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_STEPS;
`endif

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic          step_evt;
  logic [7:0]    fill_nxt;
  logic [7:0]    drain_nxt;

  assign step_evt  = en && (presc == PW'(DIV - 1));
  assign fill_nxt  = {1'b1, out[7:1]};
  assign drain_nxt = {1'b0, out[7:1]};

  always_ff @(posedge clk_50M) begin
    if (reset)
      presc <= '0;
    else if (en)
      presc <= step_evt ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      out   <= 8'h00;
      phase <= FILL;
      step  <= 1'b0;
`ifdef LED_HOLD_EN
      hold_cnt <= '0;
`endif
    end else begin
      step <= step_evt;
      if (step_evt) begin
        case (phase)
          FILL: begin
            out <= fill_nxt;
            if (fill_nxt == 8'hFF) begin
`ifdef LED_HOLD_EN
              phase    <= HOLD_FULL;
              hold_cnt <= '0;
`else
              phase <= DRAIN;
`endif
            end
          end
          DRAIN: begin
            out <= drain_nxt;
            if (drain_nxt == 8'h00) begin
`ifdef LED_HOLD_EN
              phase    <= HOLD_EMPTY;
              hold_cnt <= '0;
`else
              phase <= FILL;
`endif
            end
          end
`ifdef LED_HOLD_EN
          // out is left untouched; the hold counter alone decides when to leave
          HOLD_FULL, HOLD_EMPTY: begin
            if (hold_cnt == HW'(HOLD_STEPS - 1))
              phase <= (phase == HOLD_FULL) ? DRAIN : FILL;
            else
              hold_cnt <= hold_cnt + HW'(1);
          end
`endif
          default: phase <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_fill_drain_rev.sv
// Scoreboard bench for led_fill_drain_rev: DIV=4 instance for timing/freeze/reset,
// DIV=1 instance for the minimum divider; expected steps queued, monitors pop on step.
module tb_led_fill_drain_rev;

  typedef struct {
    logic [7:0] out;
    logic [1:0] ph;
    int         tick;
  } exp_t;

`ifdef LED_HOLD_EN
  localparam int PER = 20;
  localparam int K3F = 12;
  logic [9:0] tbl [PER] = '{
    {8'h80,2'd0}, {8'hC0,2'd0}, {8'hE0,2'd0}, {8'hF0,2'd0}, {8'hF8,2'd0},
    {8'hFC,2'd0}, {8'hFE,2'd0}, {8'hFF,2'd1}, {8'hFF,2'd1}, {8'hFF,2'd2},
    {8'h7F,2'd2}, {8'h3F,2'd2}, {8'h1F,2'd2}, {8'h0F,2'd2}, {8'h07,2'd2},
    {8'h03,2'd2}, {8'h01,2'd2}, {8'h00,2'd3}, {8'h00,2'd3}, {8'h00,2'd0}};
`else
  localparam int PER = 16;
  localparam int K3F = 10;
  logic [9:0] tbl [PER] = '{
    {8'h80,2'd0}, {8'hC0,2'd0}, {8'hE0,2'd0}, {8'hF0,2'd0},
    {8'hF8,2'd0}, {8'hFC,2'd0}, {8'hFE,2'd0}, {8'hFF,2'd2},
    {8'h7F,2'd2}, {8'h3F,2'd2}, {8'h1F,2'd2}, {8'h0F,2'd2},
    {8'h07,2'd2}, {8'h03,2'd2}, {8'h01,2'd2}, {8'h00,2'd0}};
`endif
  localparam int NS = PER + 4;

  logic       clk = 1'b0;
  logic       reset_a, en_a, reset_b, en_b;
  logic [7:0] out_a, out_b;
  logic [1:0] phase_a, phase_b;
  logic       step_a, step_b;
  int         cnt_a = 0, cnt_b = 0;
  int         n_cmp = 0, n_bad = 0;
  exp_t       q_a[$], q_b[$];
  exp_t       e_a, e_b;

  always #10 clk = ~clk;

  led_fill_drain_rev #(.DIV(4), .HOLD_STEPS(2)) dut_a (
    .clk_50M(clk), .reset(reset_a), .en(en_a),
    .out(out_a), .phase(phase_a), .step(step_a));

  led_fill_drain_rev #(.DIV(1), .HOLD_STEPS(2)) dut_b (
    .clk_50M(clk), .reset(reset_b), .en(en_b),
    .out(out_b), .phase(phase_b), .step(step_b));

  // enabled-cycle counters, used as the expected arrival time of each step
  always @(posedge clk) begin
    if (reset_a) cnt_a <= 0; else if (en_a) cnt_a <= cnt_a + 1;
    if (reset_b) cnt_b <= 0; else if (en_b) cnt_b <= cnt_b + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input int k);
    exp_t e;
    e.out = tbl[(k-1) % PER][9:2]; e.ph = tbl[(k-1) % PER][1:0]; e.tick = 4 * k;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int k);
    exp_t e;
    e.out = tbl[(k-1) % PER][9:2]; e.ph = tbl[(k-1) % PER][1:0]; e.tick = k;
    q_b.push_back(e);
  endtask

  always @(negedge clk) begin
    if (step_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_step: got out=%0h phase=%0d at cycle %0d, expected no step", out_a, phase_a, cnt_a);
      end else begin
        e_a = q_a.pop_front();
        check("a_out", 32'(out_a), 32'(e_a.out));
        check("a_phase", 32'(phase_a), 32'(e_a.ph));
        check("a_tick", cnt_a, e_a.tick);
      end
    end
  end

  always @(negedge clk) begin
    if (step_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_step: got out=%0h phase=%0d at cycle %0d, expected no step", out_b, phase_b, cnt_b);
      end else begin
        e_b = q_b.pop_front();
        check("b_out", 32'(out_b), 32'(e_b.out));
        check("b_phase", 32'(phase_b), 32'(e_b.ph));
        check("b_tick", cnt_b, e_b.tick);
      end
    end
  end

  initial begin
    reset_a = 1'b1; en_a = 1'b0; reset_b = 1'b1; en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out_a), 32'h00);
    check("rst_phase", 32'(phase_a), 32'd0);
    check("rst_step", 32'(step_a), 32'd0);

    // fill timing and freeze on DIV=4
    reset_a = 1'b0; en_a = 1'b1;
    for (int k = 1; k <= 3; k++) push_a(k);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pre_step_out", 32'(out_a), 32'h00);
      check("pre_step_step", 32'(step_a), 32'd0);
    end
    repeat (11) @(negedge clk);
    check("freeze_entry_out", 32'(out_a), 32'hE0);
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("freeze_out", 32'(out_a), 32'hE0);
      check("freeze_phase", 32'(phase_a), 32'd0);
      check("freeze_step", 32'(step_a), 32'd0);
    end
    en_a = 1'b1;
    for (int k = 4; k <= NS; k++) push_a(k);
    repeat (4 * NS - 14 + 1) @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);

    // reset coincident with a pending DRAIN step at out=3F
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    for (int k = 1; k <= K3F; k++) push_a(k);
    repeat (4 * K3F + 3) @(negedge clk);
    check("pre_reset_out", 32'(out_a), 32'h3F);
    check("pre_reset_phase", 32'(phase_a), 32'd2);
    reset_a = 1'b1;
    @(negedge clk);
    check("mid_reset_out", 32'(out_a), 32'h00);
    check("mid_reset_phase", 32'(phase_a), 32'd0);
    check("mid_reset_step", 32'(step_a), 32'd0);
    en_a = 1'b0;
    @(negedge clk);
    check("a_queue_after_reset", q_a.size(), 0);

    // minimum divider: a step on every enabled cycle
    reset_b = 1'b0; en_b = 1'b1;
    for (int k = 1; k <= 9; k++) push_b(k);
    repeat (9) @(negedge clk);
    en_b = 1'b0;
    @(negedge clk);
    check("b_stop_step", 32'(step_b), 32'd0);
    check("b_queue_drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_fill_drain_rev.md
LED_FILL_DRAIN_REV -- requirements
Module: led_fill_drain_rev

Interface
REQ-001 SHALL have parameter DIV, default 25000000, clk_50M cycles per pattern step; legal range is 1 or greater.
REQ-002 SHALL have parameter HOLD_STEPS, default 2, steps spent in each hold phase; legal range is 1 or greater; used only when LED_HOLD_EN is defined.
REQ-003 SHALL have port clk_50M, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit; 1 = prescaler and pattern advance, 0 = everything frozen.
REQ-006 SHALL have port out, output, 8 bits, registered LED drive, 1 = LED lit.
REQ-007 SHALL have port phase, output, 2 bits, registered current state: 00 FILL, 01 HOLD_FULL, 10 DRAIN, 11 HOLD_EMPTY.
REQ-008 SHALL have port step, output, 1 bit, registered one-cycle pulse marking each pattern step.

Function
REQ-009 SHALL run a prescaler from 0 to DIV-1 that increments only on cycles with en=1 and wraps to 0 after DIV-1.
REQ-010 SHALL generate an internal step event on the enabled cycle where the prescaler equals DIV-1; with DIV=1, every enabled cycle is a step.
REQ-011 SHALL assert step for exactly the one cycle in which out or state updates, and hold it 0 otherwise.
REQ-012 SHALL, on a step in FILL, load out with {1, out[7:1]}; LEDs light from bit 7 toward bit 0, giving 80, C0, E0 ... FF.
REQ-013 SHALL, on the FILL step that makes out equal FF, move to HOLD_FULL (or straight to DRAIN when holds are compiled out).
REQ-014 SHALL, on a step in DRAIN, load out with {0, out[7:1]}; LEDs turn off from bit 7 first, giving 7F, 3F ... 00.
REQ-015 SHALL, on the DRAIN step that makes out equal 00, move to HOLD_EMPTY (or straight to FILL when holds are compiled out).
REQ-016 SHALL, in either hold state, keep out unchanged and count steps; on the HOLD_STEPS-th step leave HOLD_FULL for DRAIN, or HOLD_EMPTY for FILL.
REQ-017 SHALL clear the hold counter on every entry to a hold state.
REQ-018 SHALL, while en=0, freeze prescaler, hold counter, state and out, and keep step=0; on re-enable, resume from the frozen prescaler value.
REQ-019 SHALL repeat the pattern with a period of 16 steps without holds, or 16 + 2*HOLD_STEPS steps with holds.
REQ-020 SHALL size the prescaler and hold counters to hold DIV-1 and HOLD_STEPS without overflow.

Reset
REQ-021 SHALL, on any clock edge with reset=1, set out=00, phase=00 (FILL), step=0, and clear the prescaler and hold counter.
REQ-022 SHALL give reset priority over en and over a coincident step, including reset asserted mid-FILL, mid-DRAIN or mid-hold.
REQ-023 SHALL, after reset deasserts, produce the first step at the DIV-th enabled cycle, with out=80.

Configuration
REQ-024 SHALL, when macro LED_HOLD_EN is defined, include the HOLD_FULL and HOLD_EMPTY states and the hold counter.
REQ-025 SHALL, when LED_HOLD_EN is undefined, omit the hold logic entirely, so phase only takes 00 and 10 and parameter HOLD_STEPS is ignored.

Verification
REQ-026 SHALL cover fill timing: DIV=4, reset then en=1 -> out=00 for the first 3 cycles, out=80 with step=1 on the 4th, out=FF after 8 steps (cycle 32).
REQ-027 SHALL cover holds: LED_HOLD_EN defined, HOLD_STEPS=2, DIV=4 -> out=FF with phase=01 for 2 steps, then 7F with phase=10; full period = 20 steps = 80 cycles.
REQ-028 SHALL cover no holds: LED_HOLD_EN undefined, DIV=4 -> step after FF gives 7F; step after 01 gives 00 then 80; period = 64 cycles; phase never 01 or 11.
REQ-029 SHALL cover freeze: en=0 at out=E0 with prescaler=2 for 10 cycles -> out, phase and prescaler unchanged, step=0; after en=1, the next step comes 2 cycles later with out=F0.
REQ-030 SHALL cover reset mid-operation: reset=1 together with en=1 and a pending step at out=3F in DRAIN -> next edge out=00, phase=00, step=0.
REQ-031 SHALL cover minimum divider: DIV=1, en=1 continuous -> step=1 every cycle; out goes 80, C0 ... FF on 8 consecutive cycles.
